// File: rtl/ide_pkg.sv
// rtl/ide_pkg.sv - shared types and constants for the IDE bus-cycle controller
// Purpose: FSM state encoding, chip-select index constants, PIO-0 default
// cycle counts and the timer load helper used by ide_cycle_ctrl.
package ide_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_IORDY_WAIT,
        ST_RECOVER,
        ST_ROM,
        ST_ACK
    } state_e;

    // Bit positions within IDE_CS_n
    localparam int CS_CMD = 0;
    localparam int CS_CTL = 1;

    // PIO mode 0 defaults at a 7.09 MHz clock
    localparam int PIO0_SETUP_CYC   = 1;
    localparam int PIO0_STROBE_CYC  = 3;
    localparam int PIO0_RECOVER_CYC = 1;
    localparam int PIO0_ROM_CYC     = 2;
    localparam int PIO0_IORDY_MAX   = 15;

    // A state lasting n cycles loads n-1 and exits when the timer reads zero.
    function automatic logic [3:0] cnt_load(input int cycles);
        return (cycles > 0) ? 4'(cycles - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/ide_cycle_ctrl_cycle_timer.sv
// rtl/ide_cycle_ctrl_cycle_timer.sv - 4-bit load/decrement down-counter with zero flag
// Purpose: times each FSM state of ide_cycle_ctrl.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load      - load load_val (takes priority over dec)
//   load_val  - value loaded on state entry
//   dec       - decrement; saturates at zero, never wraps
//   zero      - counter currently reads zero
module cycle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/ide_cycle_ctrl.sv
// rtl/ide_cycle_ctrl.sv - Zorro II IDE PIO / boot-ROM bus-cycle controller
// Purpose: turns a decoded 68000 access into a timed IDE register cycle or a
// boot-ROM cycle and returns DTACK. All outputs are registered.
// Ports:
//   CLK, RESET           - 7.09 MHz clock, asynchronous active-high reset
//   ADDR[16:1]           - CPU address within the 128K window
//   AS_n, UDS_n, LDS_n   - 68000 address / data strobes
//   RW                   - 1 = read
//   ide_access           - window hit from the autoconfig stage
//   IORDY                - drive ready, already synchronised
//   IDE_CS_n[1:0]        - [0] CS0 command block, [1] CS1 control block
//   IDE_A[2:0]           - drive register address
//   IDE_IOR_n, IDE_IOW_n - drive strobes
//   ROM_OE_n             - boot ROM output enable
//   BUF_OE_n, BUF_DIR    - data buffer enable / direction (1 = card drives bus)
//   rd_latch             - one-cycle pulse to latch drive read data
//   dtack                - cycle complete
module ide_cycle_ctrl
    import ide_pkg::*;
#(
    parameter int SETUP_CYC   = PIO0_SETUP_CYC,
    parameter int STROBE_CYC  = PIO0_STROBE_CYC,
    parameter int RECOVER_CYC = PIO0_RECOVER_CYC,
    parameter int ROM_CYC     = PIO0_ROM_CYC,
    parameter int IORDY_MAX   = PIO0_IORDY_MAX
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [16:1] ADDR,
    input  logic        AS_n,
    input  logic        UDS_n,
    input  logic        LDS_n,
    input  logic        RW,
    input  logic        ide_access,
    input  logic        IORDY,
    output logic [1:0]  IDE_CS_n,
    output logic [2:0]  IDE_A,
    output logic        IDE_IOR_n,
    output logic        IDE_IOW_n,
    output logic        ROM_OE_n,
    output logic        BUF_OE_n,
    output logic        BUF_DIR,
    output logic        rd_latch,
    output logic        dtack
);

    localparam logic [3:0] LD_SETUP   = cnt_load(SETUP_CYC);
    localparam logic [3:0] LD_STROBE  = cnt_load(STROBE_CYC);
    localparam logic [3:0] LD_RECOVER = cnt_load(RECOVER_CYC);
    localparam logic [3:0] LD_ROM     = cnt_load(ROM_CYC);
    localparam logic [3:0] LD_IORDY   = cnt_load(IORDY_MAX);
    localparam logic       HAS_WAIT   = (IORDY_MAX > 0);

    state_e state_q, state_d;

    // Cycle context captured at entry and held until IDLE
    logic       rw_q, rw_d;
    logic       cs_sel_q, cs_sel_d;
    logic [2:0] a_q, a_d;
    logic       is_ide_q, is_ide_d;
    // AS_n seen high during the strobe or recovery: finish without DTACK
    logic       abort_q, abort_d;
    // AS_n has been high on some edge since the last accepted cycle
    logic       arm_q, arm_d;

    logic [1:0] ide_cs_n_q, ide_cs_n_d;
    logic [2:0] ide_a_q, ide_a_d;
    logic       ior_n_q, ior_n_d;
    logic       iow_n_q, iow_n_d;
    logic       rom_oe_n_q, rom_oe_n_d;
    logic       buf_oe_n_q, buf_oe_n_d;
    logic       buf_dir_q, buf_dir_d;
    logic       rd_latch_q, rd_latch_d;
    logic       dtack_q, dtack_d;

    logic       tmr_load;
    logic [3:0] tmr_val;
    logic       tmr_dec;
    logic       tmr_zero;

    logic       start;
    logic       in_ide;
    logic       rom_ack_rd;
    logic       strobing;

    // Address bits outside the decode are intentionally ignored
    logic unused_addr;
    assign unused_addr = ^{ADDR[15:13], ADDR[11:5], ADDR[1]};

    cycle_timer u_timer (
        .clk      (CLK),
        .rst      (RESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign start = ide_access && !AS_n && (!UDS_n || !LDS_n) && arm_q;

    always_comb begin
        state_d  = state_q;
        rw_d     = rw_q;
        cs_sel_d = cs_sel_q;
        a_d      = a_q;
        is_ide_d = is_ide_q;
        abort_d  = abort_q;
        arm_d    = arm_q | AS_n;
        tmr_load = 1'b0;
        tmr_val  = 4'd0;
        tmr_dec  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    rw_d     = RW;
                    cs_sel_d = ADDR[12];
                    a_d      = ADDR[4:2];
                    is_ide_d = ADDR[16];
                    arm_d    = 1'b0;
                    if (ADDR[16]) begin
                        state_d  = ST_SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = LD_SETUP;
                    end else if (RW) begin
                        state_d  = ST_ROM;
                        tmr_load = 1'b1;
                        tmr_val  = LD_ROM;
                    end else begin
                        // ROM writes have nothing to strobe: ack at once
                        state_d = ST_ACK;
                    end
                end
            end
            ST_SETUP: begin
                if (AS_n) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
                    state_d  = ST_STROBE;
                    tmr_load = 1'b1;
                    tmr_val  = LD_STROBE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_STROBE: begin
                if (AS_n) begin
                    abort_d = 1'b1;
                end
                if (tmr_zero) begin
                    // An aborted cycle only needs the minimum strobe width
                    if (HAS_WAIT && !IORDY && !(abort_q || AS_n)) begin
                        state_d  = ST_IORDY_WAIT;
                        tmr_load = 1'b1;
                        tmr_val  = LD_IORDY;
                    end else begin
                        state_d  = ST_RECOVER;
                        tmr_load = 1'b1;
                        tmr_val  = LD_RECOVER;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_IORDY_WAIT: begin
                if (AS_n) begin
                    abort_d = 1'b1;
                end
                // Timeout completes the cycle normally
                if (AS_n || IORDY || tmr_zero) begin
                    state_d  = ST_RECOVER;
                    tmr_load = 1'b1;
                    tmr_val  = LD_RECOVER;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RECOVER: begin
                if (AS_n) begin
                    abort_d = 1'b1;
                end
                if (tmr_zero) begin
                    state_d = (abort_q || AS_n) ? ST_IDLE : ST_ACK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ROM: begin
                if (AS_n) begin
                    state_d = ST_IDLE;
                end else if (tmr_zero) begin
                    state_d = ST_ACK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ACK: begin
                if (AS_n) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they change on the same
        // edge as the state register.
        in_ide     = (state_d inside {ST_SETUP, ST_STROBE, ST_IORDY_WAIT, ST_RECOVER}) ||
                     ((state_d == ST_ACK) && is_ide_d);
        rom_ack_rd = (state_d == ST_ACK) && !is_ide_d && rw_d;
        strobing   = state_d inside {ST_STROBE, ST_IORDY_WAIT};

        ide_cs_n_d = 2'b11;
        if (in_ide) begin
            if (cs_sel_d) begin
                ide_cs_n_d[CS_CTL] = 1'b0;
            end else begin
                ide_cs_n_d[CS_CMD] = 1'b0;
            end
        end
        ide_a_d    = in_ide ? a_d : 3'd0;
        ior_n_d    = !(strobing && rw_d);
        iow_n_d    = !(strobing && !rw_d);
        rom_oe_n_d = !((state_d == ST_ROM) || rom_ack_rd);
        buf_oe_n_d = !(in_ide || (state_d == ST_ROM) || rom_ack_rd);
        buf_dir_d  = (state_d != ST_IDLE) && rw_d;
        rd_latch_d = rw_d && (state_q inside {ST_STROBE, ST_IORDY_WAIT}) &&
                     (state_d == ST_RECOVER);
        dtack_d    = (state_d == ST_ACK);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            rw_q       <= 1'b0;
            cs_sel_q   <= 1'b0;
            a_q        <= 3'd0;
            is_ide_q   <= 1'b0;
            abort_q    <= 1'b0;
            arm_q      <= 1'b0;
            ide_cs_n_q <= 2'b11;
            ide_a_q    <= 3'd0;
            ior_n_q    <= 1'b1;
            iow_n_q    <= 1'b1;
            rom_oe_n_q <= 1'b1;
            buf_oe_n_q <= 1'b1;
            buf_dir_q  <= 1'b0;
            rd_latch_q <= 1'b0;
            dtack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            cs_sel_q   <= cs_sel_d;
            a_q        <= a_d;
            is_ide_q   <= is_ide_d;
            abort_q    <= abort_d;
            arm_q      <= arm_d;
            ide_cs_n_q <= ide_cs_n_d;
            ide_a_q    <= ide_a_d;
            ior_n_q    <= ior_n_d;
            iow_n_q    <= iow_n_d;
            rom_oe_n_q <= rom_oe_n_d;
            buf_oe_n_q <= buf_oe_n_d;
            buf_dir_q  <= buf_dir_d;
            rd_latch_q <= rd_latch_d;
            dtack_q    <= dtack_d;
        end
    end

    assign IDE_CS_n  = ide_cs_n_q;
    assign IDE_A     = ide_a_q;
    assign IDE_IOR_n = ior_n_q;
    assign IDE_IOW_n = iow_n_q;
    assign ROM_OE_n  = rom_oe_n_q;
    assign BUF_OE_n  = buf_oe_n_q;
    assign BUF_DIR   = buf_dir_q;
    assign rd_latch  = rd_latch_q;
    assign dtack     = dtack_q;

endmodule

// File: tb/tb_ide_cycle_ctrl.sv
// tb/tb_ide_cycle_ctrl.sv - self-checking bench for ide_cycle_ctrl
module tb_ide_cycle_ctrl;

    localparam int S  = 1;
    localparam int T  = 3;
    localparam int R  = 1;
    localparam int RC = 2;
    localparam int IM = 15;
    localparam logic [12:0] IDLE_OUTS = 13'b11_000_1_1_1_1_0_0_0;
    localparam int STUCK = 16;

    typedef struct {
        logic [1:0] cs;
        logic [2:0] a;
        logic [1:0] bufs;
        int         strobe;
        int         dtack_k;
        int         rdl;
        int         rom;
    } exp_t;

    typedef struct {
        logic [16:1] addr;
        bit          rw;
        int          iordy_low;
        int          abort_k;
        exp_t        e;
    } vec_t;

    logic        CLK, RESET;
    logic [16:1] ADDR;
    logic        AS_n, UDS_n, LDS_n, RW, ide_access, IORDY;
    logic [1:0]  IDE_CS_n;
    logic [2:0]  IDE_A;
    logic        IDE_IOR_n, IDE_IOW_n, ROM_OE_n, BUF_OE_n, BUF_DIR, rd_latch, dtack;
    logic [12:0] outs;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    vec_t vecs[10];

    ide_cycle_ctrl #(
        .SETUP_CYC   (S),
        .STROBE_CYC  (T),
        .RECOVER_CYC (R),
        .ROM_CYC     (RC),
        .IORDY_MAX   (IM)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .ADDR       (ADDR),
        .AS_n       (AS_n),
        .UDS_n      (UDS_n),
        .LDS_n      (LDS_n),
        .RW         (RW),
        .ide_access (ide_access),
        .IORDY      (IORDY),
        .IDE_CS_n   (IDE_CS_n),
        .IDE_A      (IDE_A),
        .IDE_IOR_n  (IDE_IOR_n),
        .IDE_IOW_n  (IDE_IOW_n),
        .ROM_OE_n   (ROM_OE_n),
        .BUF_OE_n   (BUF_OE_n),
        .BUF_DIR    (BUF_DIR),
        .rd_latch   (rd_latch),
        .dtack      (dtack)
    );

    assign outs = {IDE_CS_n, IDE_A, IDE_IOR_n, IDE_IOW_n, ROM_OE_n, BUF_OE_n,
                   BUF_DIR, rd_latch, dtack};

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [16:1] mk_addr(input bit ide, input bit cs, input logic [2:0] a);
        logic [16:1] r;
        r      = 16'($urandom);
        r[16]  = ide;
        r[12]  = cs;
        r[4:2] = a;
        return r;
    endfunction

    function automatic vec_t mk_vec(input bit ide, input bit cs, input logic [2:0] a,
                                    input bit rw, input int iordy_low, input int abort_k,
                                    input logic [1:0] e_cs, input logic [1:0] e_bufs,
                                    input int e_strobe, input int e_dtack,
                                    input int e_rdl, input int e_rom);
        vec_t v;
        v.addr      = mk_addr(ide, cs, a);
        v.rw        = rw;
        v.iordy_low = iordy_low;
        v.abort_k   = abort_k;
        v.e.cs      = e_cs;
        v.e.a       = ide ? a : 3'd0;
        v.e.bufs    = e_bufs;
        v.e.strobe  = e_strobe;
        v.e.dtack_k = e_dtack;
        v.e.rdl     = e_rdl;
        v.e.rom     = e_rom;
        return v;
    endfunction

    // Edge k=1 is the edge that samples the access.
    task automatic run_cycle(input int id, input vec_t v);
        exp_t       e;
        logic [1:0] o_cs;
        logic [2:0] o_a;
        logic [1:0] o_bufs;
        int         o_strobe = 0, o_wrong = 0, o_rom = 0, o_rdl = 0, o_rdl_bad = 0;
        int         o_dtack = 0, rel_k = 0;
        logic [12:0] o_idle;
        logic       prev_ior = 1'b1;
        bit         done = 0;
        o_cs = 2'b00; o_a = 3'd0; o_bufs = 2'b00; o_idle = 13'd0;

        exp_q.push_back(v.e);
        ADDR = v.addr; RW = v.rw; AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0;
        ide_access = 1'b1; IORDY = (v.iordy_low == 0);
        for (int k = 1; k <= 40 && !done; k++) begin
            @(posedge CLK); #1;
            if (k == 1) begin
                o_cs = IDE_CS_n; o_a = IDE_A; o_bufs = {BUF_OE_n, BUF_DIR};
            end
            if (!(v.rw ? IDE_IOR_n : IDE_IOW_n)) o_strobe++;
            if (!(v.rw ? IDE_IOW_n : IDE_IOR_n)) o_wrong++;
            if (!ROM_OE_n) o_rom++;
            if (rd_latch) begin
                o_rdl++;
                if (!(prev_ior == 1'b0 && IDE_IOR_n == 1'b1)) o_rdl_bad++;
            end
            prev_ior = IDE_IOR_n;
            if (dtack && o_dtack == 0) o_dtack = k;
            if (v.iordy_low > 0 && v.iordy_low < STUCK && k == 4 + v.iordy_low) IORDY = 1'b1;
            if (rel_k != 0 && k == rel_k + ((v.abort_k != 0) ? 8 : 1)) begin
                o_idle = outs;
                done = 1;
            end
            if (rel_k == 0 && ((v.abort_k != 0 && k == v.abort_k) || (v.abort_k == 0 && dtack == 1'b1))) begin
                rel_k = k;
                AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; ide_access = 1'b0;
            end
        end
        if (!done) o_idle = outs;
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; ide_access = 1'b0; IORDY = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        e = exp_q.pop_front();
        check($sformatf("v%0d_cs_n", id), int'(o_cs), int'(e.cs));
        check($sformatf("v%0d_ide_a", id), int'(o_a), int'(e.a));
        check($sformatf("v%0d_buf", id), int'(o_bufs), int'(e.bufs));
        check($sformatf("v%0d_strobe_len", id), o_strobe, e.strobe);
        check($sformatf("v%0d_wrong_strobe", id), o_wrong, 0);
        check($sformatf("v%0d_dtack_edge", id), o_dtack, e.dtack_k);
        check($sformatf("v%0d_rd_latch", id), o_rdl, e.rdl);
        check($sformatf("v%0d_rd_latch_align", id), o_rdl_bad, 0);
        check($sformatf("v%0d_rom_oe_len", id), o_rom, e.rom);
        check($sformatf("v%0d_idle_after", id), int'(o_idle), int'(IDLE_OUTS));
    endtask

    initial begin
        CLK = 1'b0; RESET = 1'b1; AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1;
        RW = 1'b1; ADDR = '0; ide_access = 1'b0; IORDY = 1'b1;

        //               ide cs a     rw iordy  abort cs_n   buf    strobe   dtack edge        rdl rom
        vecs[0] = mk_vec(1, 0, 3'd0, 1, 0,     0,    2'b10, 2'b01, T,       1+S+T+R,          1,  0);
        vecs[1] = mk_vec(1, 1, 3'd7, 0, 4,     0,    2'b01, 2'b00, T+4,     1+S+T+4+R,        0,  0);
        vecs[2] = mk_vec(1, 1, 3'd3, 1, STUCK, 0,    2'b01, 2'b01, T+IM,    1+S+T+IM+R,       1,  0);
        vecs[3] = mk_vec(1, 0, 3'd5, 0, STUCK, 0,    2'b10, 2'b00, T+IM,    1+S+T+IM+R,       0,  0);
        vecs[4] = mk_vec(1, 0, 3'd6, 1, 1,     0,    2'b10, 2'b01, T+1,     1+S+T+1+R,        1,  0);
        vecs[5] = mk_vec(0, 0, 3'd0, 1, 0,     0,    2'b11, 2'b01, 0,       1+RC,             0,  RC+1);
        vecs[6] = mk_vec(0, 0, 3'd0, 0, 0,     0,    2'b11, 2'b10, 0,       1,                0,  0);
        vecs[7] = mk_vec(1, 0, 3'd1, 1, 0,     1,    2'b10, 2'b01, 0,       0,                0,  0);
        vecs[8] = mk_vec(1, 1, 3'd2, 1, 0,     3,    2'b01, 2'b01, T,       0,                1,  0);
        vecs[9] = mk_vec(0, 0, 3'd0, 1, 0,     1,    2'b11, 2'b01, 0,       0,                0,  1);

        repeat (2) @(posedge CLK);
        #1;
        check("reset_state", int'(outs), int'(IDLE_OUTS));
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        for (int i = 0; i < 10; i++) begin
            run_cycle(i, vecs[i]);
        end

        // Reset in the middle of a read strobe, then a normal cycle.
        ADDR = mk_addr(1, 0, 3'd4); RW = 1'b1; AS_n = 1'b0; UDS_n = 1'b0; LDS_n = 1'b0;
        ide_access = 1'b1; IORDY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("pre_reset_ior", int'(IDE_IOR_n), 0);
        RESET = 1'b1;
        #1;
        check("reset_async", int'(outs), int'(IDLE_OUTS));
        @(posedge CLK); #1;
        RESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge CLK); #1;
            check("no_restart_cs", int'(IDE_CS_n), 3);
        end
        AS_n = 1'b1; UDS_n = 1'b1; LDS_n = 1'b1; ide_access = 1'b0;
        @(posedge CLK); #1;
        run_cycle(10, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
